vpu_lcd_pixel_fifo: RTL

//  Elastic stage between vpu_core pixel output and the ILI9341 8-bit parallel LCD driver.

---
 rtl/vpu_lcd_pixel_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vpu_lcd_pixel_fifo.sv
// Pixel FIFO between vpu_core and the ILI9341 byte driver: packs ABGR8888 to RGB565
// (RGB666 with PIXEL_FIFO_RGB666_EN), buffers entries and serializes them high byte first.
module vpu_lcd_pixel_fifo #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  pix_valid,
  input  logic [31:0]           pix_color,
  input  logic                  pix_sof,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  output logic                  byte_sof,
  input  logic                  byte_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  ovf_clear
);

`ifdef PIXEL_FIFO_RGB666_EN
  localparam int ENTRY_W = 19;
`else
  localparam int ENTRY_W = 17;
`endif
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYTE0,
    S_BYTE1,
    S_BYTE2
  } ser_state_t;

  ser_state_t state_q, state_d;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    entry;
  logic [ENTRY_W-1:0]    word_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  full, empty, drop, do_push, do_pop, accept, last_byte;
  logic                  unused_color_bits;

  // Colour reduction happens before the write so the FIFO only stores what the panel uses.
  always_comb begin
`ifdef PIXEL_FIFO_RGB666_EN
    entry = {pix_sof, pix_color[7:2], pix_color[15:10], pix_color[23:18]};
    unused_color_bits = ^{pix_color[31:24], pix_color[17:16], pix_color[9:8], pix_color[1:0]};
`else
    entry = {pix_sof, pix_color[7:3], pix_color[15:10], pix_color[23:19]};
    unused_color_bits = ^{pix_color[31:24], pix_color[18:16], pix_color[9:8], pix_color[2:0]};
`endif
  end

  // Full is judged on the pre-edge level, so a same-cycle pop never makes room for a push.
  always_comb begin
    full      = (fifo_level == LEVEL_FULL);
    empty     = (fifo_level == '0);
    drop      = pix_valid && full;
    accept    = byte_valid && byte_ready;
`ifdef PIXEL_FIFO_RGB666_EN
    last_byte = (state_q == S_BYTE2);
`else
    last_byte = (state_q == S_BYTE1);
`endif
    do_push   = pix_valid && !full && !flush;
    do_pop    = !flush && !empty && ((state_q == S_IDLE) || (last_byte && accept));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_BYTE0;
      S_BYTE0: if (accept) state_d = S_BYTE1;
`ifdef PIXEL_FIFO_RGB666_EN
      S_BYTE1: if (accept) state_d = S_BYTE2;
      S_BYTE2: if (accept) state_d = empty ? S_IDLE : S_BYTE0;
`else
      S_BYTE1: if (accept) state_d = empty ? S_IDLE : S_BYTE0;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from the held word, so they cannot change while stalled.
  always_comb begin
    byte_valid = (state_q != S_IDLE);
    byte_data  = 8'h00;
    byte_sof   = 1'b0;
    case (state_q)
`ifdef PIXEL_FIFO_RGB666_EN
      S_BYTE0: begin
        byte_data = {word_q[17:12], 2'b00};
        byte_sof  = word_q[18];
      end
      S_BYTE1: byte_data = {word_q[11:6], 2'b00};
      S_BYTE2: byte_data = {word_q[5:0], 2'b00};
`else
      S_BYTE0: begin
        byte_data = word_q[15:8];
        byte_sof  = word_q[16];
      end
      S_BYTE1: byte_data = word_q[7:0];
`endif
      default: byte_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      word_q     <= '0;
    end else if (flush) begin
      state_q    <= S_IDLE;
      rd_ptr     <= wr_ptr;
      fifo_level <= '0;
    end else begin
      state_q <= state_d;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        word_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
        2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

endmodule
